apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
//  APB3 initiator (master). It converts single-beat commands from a local valid/ready
//  port into APB SETUP/ACCESS transfers toward apb_ram or any APB completer.
//  It returns one response per command, carrying read data and an error flag.
//  A wait-state watchdog aborts transfers whose completer never raises pready.
// PARAMETERS
//  ADDR_W   32  width of cmd_addr / paddr
//  DATA_W   32  width of write/read data
//  TIMEOUT  64  max ACCESS cycles before abort, range 1..65535; 0 disables the watchdog
// PORTS
//  pclk         in   1       clock; all logic on rising edge
//  preset       in   1       synchronous active-high reset
//  cmd_valid    in   1       command request
//  cmd_ready    out  1       command accepted when cmd_valid && cmd_ready
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  transfer address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       one-cycle response pulse; no backpressure
//  rsp_rdata    out  DATA_W  read data; 0 for writes and for timeouts
//  rsp_err      out  1       pslverr sampled, or timeout
//  rsp_timeout  out  1       transfer aborted by the watchdog
//  busy         out  1       high from accept until the rsp_valid cycle (exclusive)
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  pwrite       out  1       APB direction
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB completer ready
//  pslverr      in   1       APB completer error
// BEHAVIOUR
//  - Reset (sync, preset=1 at edge) clears all outputs and sets state=IDLE.
//    psel, penable, pwrite, rsp_* and busy = 0; paddr, pwdata = 0; cmd_ready = 1 after reset.
//  - All outputs are registered, except cmd_ready = (state==IDLE) && !preset.
//  - FSM states: IDLE, SETUP, ACCESS.
//  - IDLE: on accept, latch write/addr/wdata into pwrite/paddr/pwdata; next state SETUP.
//    In SETUP, psel=1 and penable=0.
//  - SETUP: unconditional move to ACCESS next cycle; penable=1; wait counter cleared to 0.
//  - ACCESS: sample pready each cycle.
//    * pready=1: next cycle psel=penable=0, state IDLE, rsp_valid=1.
//      rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes; rsp_timeout=0.
//    * pready=0 and (TIMEOUT==0 or wait_cnt<TIMEOUT-1): stay in ACCESS, wait_cnt+=1.
//      psel, penable, paddr, pwdata and pwrite are all held stable.
//    * pready=0 and wait_cnt==TIMEOUT-1: abort. Next cycle psel=penable=0, state IDLE.
//      rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//    * pready=1 on the final allowed cycle completes normally; no timeout is reported.
//  - Minimum latency: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
//    Next accept is possible at 3, so one command completes every 3 cycles, plus wait states.
//  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
//    rsp_valid is high for exactly 1 cycle per accepted command.
//  - paddr, pwdata and pwrite hold their last values in IDLE (no toggling between transfers).
//  - cmd_valid while busy: ignored (cmd_ready=0); the requester must hold the command.
//  - wait_cnt is 16 bits and saturates; with TIMEOUT=0 it never triggers an abort.
//  - Reset mid-transfer (any state): next edge psel=penable=0, state IDLE.
//    No rsp_valid is produced for the killed transfer.
// TESTING
//  1. Write 0x5 <- 0xDEADBEEF, pready=1 in first ACCESS -> psel=1 cycles 1-2, penable=1 cycle 2,
//     pwrite=1 and paddr=0x5 stable in both; rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0.
//  2. Read 0x5 against an apb_ram model (pready after 1 wait state) -> rsp_rdata=0xDEADBEEF,
//     rsp_err=0, rsp_valid at cycle 4, paddr held through both ACCESS cycles.
//  3. Read 0x28 (40), completer returns pslverr=1 -> rsp_err=1, rsp_timeout=0,
//     rsp_rdata=prdata as driven.
//  4. TIMEOUT=16, pready tied 0 -> ACCESS lasts exactly 16 cycles, psel drops,
//     rsp_valid=1 with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//     Repeat with pready=1 on the 16th cycle -> normal completion, rsp_timeout=0.
//  5. Hold cmd_valid with a second command during transfer 1 -> cmd_ready=0 until rsp cycle,
//     second command accepted that cycle; its psel rises the following cycle,
//     with exactly 1 rsp_valid per command.
//  6. Assert preset for 1 cycle while in ACCESS -> psel=penable=0 next edge, no rsp_valid,
//     cmd_ready=1, busy=0; the next command runs normally.

Source files
------------

// File: rtl/apb_requester_if.sv
// Bundles the local command/response port and the APB3 bus of the requester.
// The master modport is the requester's view; slave is the command source plus completer.
interface apb_requester_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_requester.sv
// APB3 initiator: turns single-beat local commands into SETUP/ACCESS transfers
// and returns one response per command; a wait-state watchdog aborts hung transfers.
module apb_requester #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               i_pclk,
    input  logic               i_preset,
    apb_requester_if.master    bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    localparam int unsigned     CNT_W    = 16;
    localparam logic            WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            r_state,       w_state;
    logic              r_psel,        w_psel;
    logic              r_penable,     w_penable;
    logic              r_pwrite,      w_pwrite;
    logic [ADDR_W-1:0] r_paddr,       w_paddr;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata;
    logic              r_rsp_valid,   w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata;
    logic              r_rsp_err,     w_rsp_err;
    logic              r_rsp_timeout, w_rsp_timeout;
    logic              r_busy,        w_busy;
    logic [CNT_W-1:0]  r_wait_cnt,    w_wait_cnt;
    logic              w_cmd_ready;

    // Only ready output is combinational so a new command can be taken in the response cycle
    assign w_cmd_ready = (r_state == S_IDLE) && !i_preset;

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state       <= S_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
            r_busy        <= w_busy;
            r_wait_cnt    <= w_wait_cnt;
        end
    end

    // Next-state and next-output logic; bus fields hold unless a transfer changes them
    always_comb begin
        w_state       = r_state;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;
        w_busy        = r_busy;
        w_wait_cnt    = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && w_cmd_ready) begin
                    w_state  = S_SETUP;
                    w_psel   = 1'b1;
                    w_pwrite = bus.cmd_write;
                    w_paddr  = bus.cmd_addr;
                    w_pwdata = bus.cmd_wdata;
                    w_busy   = 1'b1;
                end
            end
            S_SETUP: begin
                w_state    = S_ACCESS;
                w_penable  = 1'b1;
                w_wait_cnt = '0;
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    w_state       = S_IDLE;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_busy        = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = bus.pslverr;
                    w_rsp_timeout = 1'b0;
                    w_rsp_rdata   = r_pwrite ? '0 : bus.prdata;
                end else if (WDOG_EN && (r_wait_cnt == CNT_LAST)) begin
                    w_state       = S_IDLE;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_busy        = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_rsp_rdata   = '0;
                end else if (r_wait_cnt != '1) begin
                    w_wait_cnt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_psel    = 1'b0;
                w_penable = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = r_busy;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: hand-timed commands against a small APB RAM,
// with error, watchdog, back-to-back and mid-transfer reset scenarios.
module tb_apb_requester;
    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    logic        force_rd;
    logic [31:0] force_rdata;
    logic [31:0] mem [0:63];

    apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .i_pclk   (clk),
        .i_preset (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Completer RAM: writes commit on a ready ACCESS cycle; reads either from RAM or a forced value
    always @(posedge clk)
        if (bus.psel && bus.penable && bus.pready && bus.pwrite)
            mem[bus.paddr[5:0]] <= bus.pwdata;

    always_comb bus.prdata = force_rd ? force_rdata : mem[bus.paddr[5:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1;
        force_rd = 1'b0;
        force_rdata = 32'h0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        tick();
        tick();
        chk("rst_cmd_ready_held", 32'(bus.cmd_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rst_psel",      32'(bus.psel), 32'h0);
        chk("rst_penable",   32'(bus.penable), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_busy",      32'(bus.busy), 32'h0);
        chk("rst_paddr",     bus.paddr, 32'h0);

        // 1: write 0x5 <- DEADBEEF, zero wait states
        bus.pready = 1'b1;
        cmd(1'b1, 32'h5, 32'hDEADBEEF);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t1_c1_psel",      32'(bus.psel), 32'h1);
        chk("t1_c1_penable",   32'(bus.penable), 32'h0);
        chk("t1_c1_pwrite",    32'(bus.pwrite), 32'h1);
        chk("t1_c1_paddr",     bus.paddr, 32'h5);
        chk("t1_c1_busy",      32'(bus.busy), 32'h1);
        chk("t1_c1_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        chk("t1_c2_psel",    32'(bus.psel), 32'h1);
        chk("t1_c2_penable", 32'(bus.penable), 32'h1);
        chk("t1_c2_paddr",   bus.paddr, 32'h5);
        chk("t1_c2_pwdata",  bus.pwdata, 32'hDEADBEEF);
        chk("t1_c2_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t1_c3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1_c3_rsp_err",   32'(bus.rsp_err), 32'h0);
        chk("t1_c3_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("t1_c3_psel",      32'(bus.psel), 32'h0);
        chk("t1_c3_busy",      32'(bus.busy), 32'h0);
        tick();
        chk("t1_c4_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("t1_c4_paddr_hold", bus.paddr, 32'h5);

        // 2: read 0x5 with one wait state
        bus.pready = 1'b0;
        cmd(1'b0, 32'h5, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("t2_c2_paddr", bus.paddr, 32'h5);
        tick();
        chk("t2_c3_penable",   32'(bus.penable), 32'h1);
        chk("t2_c3_paddr",     bus.paddr, 32'h5);
        chk("t2_c3_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        bus.pready = 1'b1;
        tick();
        chk("t2_c4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t2_c4_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("t2_c4_rsp_err",   32'(bus.rsp_err), 32'h0);

        // 3: read 0x28 with pslverr
        force_rd = 1'b1;
        force_rdata = 32'h12345678;
        bus.pslverr = 1'b1;
        cmd(1'b0, 32'h28, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t3_c1_paddr", bus.paddr, 32'h28);
        tick();
        tick();
        chk("t3_rsp_valid",   32'(bus.rsp_valid), 32'h1);
        chk("t3_rsp_err",     32'(bus.rsp_err), 32'h1);
        chk("t3_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        chk("t3_rsp_rdata",   bus.rsp_rdata, 32'h12345678);
        force_rd = 1'b0;
        bus.pslverr = 1'b0;
        tick();
        chk("t3_rdata_hold", bus.rsp_rdata, 32'h12345678);
        chk("t3_err_hold",   32'(bus.rsp_err), 32'h1);

        // 4a: watchdog, pready stuck low -> 16 ACCESS cycles then abort
        bus.pready = 1'b0;
        cmd(1'b0, 32'h5, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_access_%0d", i), {30'h0, bus.psel, bus.penable}, 32'h3);
            tick();
        end
        chk("t4_rsp_valid",   32'(bus.rsp_valid), 32'h1);
        chk("t4_rsp_err",     32'(bus.rsp_err), 32'h1);
        chk("t4_rsp_timeout", 32'(bus.rsp_timeout), 32'h1);
        chk("t4_rsp_rdata",   bus.rsp_rdata, 32'h0);
        chk("t4_psel",        32'(bus.psel), 32'h0);

        // 4b: pready on the 16th ACCESS cycle completes normally
        cmd(1'b0, 32'h5, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t4b_c17_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        bus.pready = 1'b1;
        tick();
        chk("t4b_rsp_valid",   32'(bus.rsp_valid), 32'h1);
        chk("t4b_rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        chk("t4b_rsp_err",     32'(bus.rsp_err), 32'h0);
        chk("t4b_rsp_rdata",   bus.rsp_rdata, 32'hDEADBEEF);

        // 5: second command held during first transfer
        cmd(1'b1, 32'h7, 32'hA5A5A5A5);
        tick();
        cmd(1'b0, 32'h7, 32'h0);
        chk("t5_c1_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        chk("t5_c2_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        tick();
        chk("t5_c3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t5_c3_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        chk("t5_c3_psel",      32'(bus.psel), 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("t5_c4_psel",      32'(bus.psel), 32'h1);
        chk("t5_c4_pwrite",    32'(bus.pwrite), 32'h0);
        chk("t5_c4_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t5_c5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("t5_c6_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t5_c6_rsp_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
        tick();
        chk("t5_c7_rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // 6: reset while in ACCESS kills the transfer without a response
        bus.pready = 1'b0;
        cmd(1'b0, 32'h5, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("t6_in_access", 32'(bus.penable), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_psel",      32'(bus.psel), 32'h0);
        chk("t6_penable",   32'(bus.penable), 32'h0);
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("t6_busy",      32'(bus.busy), 32'h0);
        chk("t6_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        bus.pready = 1'b1;
        tick();
        chk("t6_no_late_rsp", 32'(bus.rsp_valid), 32'h0);
        cmd(1'b0, 32'h5, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("t6_next_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t6_next_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
